// File: rtl/taylor_seq.sv
// -----------------------------------------------------------------------------
// taylor_seq
//   Multi-cycle exp(x) Taylor evaluator. A 6th-order Horner chain around the
//   expansion point a is scheduled over one shared fixed-point multiplier and
//   one shared fixed-point adder:
//     exp(x) ~= exp(a) * (1 + d(1 + d(1/2 + d(1/6 + d(1/24 + d(1/120 + d/720))))))
//   with d = x - a. Each clock cycle does at most one multiply or one add.
//
// Ports
//   IN_CLK                      clock, rising edge
//   IN_RST_N                    synchronous active-low reset
//   IN_START                    request, sampled only while idle
//   IN_X_INT / IN_X_FRAC        operand x
//   IN_A_INT / IN_A_FRAC        expansion point a
//   IN_EXP_INT / IN_EXP_FRAC    exp(a)
//   OUT_BUSY                    high from the accept edge until the result edge
//   OUT_DONE                    one-cycle pulse, result valid in that cycle
//   OUT_EXP_INT / OUT_EXP_FRAC  result, held until the next result or reset
//
// Arithmetic
//   fix_adder      : two's complement add over the int:frac word, wrapping.
//   fix_multiplier : signed full product, arithmetic shift right by the
//                    fraction width (truncation toward -inf), low int:frac
//                    bits kept (wrapping). No saturation, no rounding.
// -----------------------------------------------------------------------------
module taylor_seq #(
    parameter int NUM_OF_INT  = 32,
    parameter int NUM_OF_FRAC = 23
) (
    input  logic                   IN_CLK,
    input  logic                   IN_RST_N,
    input  logic                   IN_START,
    input  logic [NUM_OF_INT-1:0]  IN_X_INT,
    input  logic [NUM_OF_FRAC-1:0] IN_X_FRAC,
    input  logic [NUM_OF_INT-1:0]  IN_A_INT,
    input  logic [NUM_OF_FRAC-1:0] IN_A_FRAC,
    input  logic [NUM_OF_INT-1:0]  IN_EXP_INT,
    input  logic [NUM_OF_FRAC-1:0] IN_EXP_FRAC,
    output logic                   OUT_BUSY,
    output logic                   OUT_DONE,
    output logic [NUM_OF_INT-1:0]  OUT_EXP_INT,
    output logic [NUM_OF_FRAC-1:0] OUT_EXP_FRAC
);

    localparam int W = NUM_OF_INT + NUM_OF_FRAC;

    localparam logic [2:0] S_IDLE = 3'd0;
    localparam logic [2:0] S_SUB  = 3'd1;
    localparam logic [2:0] S_MUL  = 3'd2;
    localparam logic [2:0] S_ADD  = 3'd3;
    localparam logic [2:0] S_FIN  = 3'd4;

    localparam logic [W-1:0] ONE_LSB   = {{(W-1){1'b0}}, 1'b1};
    localparam logic [W-1:0] ONE_FIX   = {{(NUM_OF_INT-1){1'b0}}, 1'b1, {NUM_OF_FRAC{1'b0}}};
    localparam logic [W-1:0] INV_720   = {{NUM_OF_INT{1'b0}}, 23'h002D82};
    localparam logic [2:0]   LAST_STEP = 3'd5;

    // fix_adder: wrapping two's complement sum
    function automatic logic [W-1:0] fix_add(input logic [W-1:0] op_a, input logic [W-1:0] op_b);
        fix_add = op_a + op_b;
    endfunction

    // fix_multiplier: signed product, drop NUM_OF_FRAC low bits, keep W bits
    function automatic logic [W-1:0] fix_mul(input logic [W-1:0] op_a, input logic [W-1:0] op_b);
        logic signed [2*W-1:0] full;
        full = $signed({{W{op_a[W-1]}}, op_a}) * $signed({{W{op_b[W-1]}}, op_b});
        fix_mul = full[NUM_OF_FRAC +: W];
    endfunction

    // Horner coefficients, innermost first (1/720 is the ACC seed)
    function automatic logic [W-1:0] coef(input logic [2:0] k);
        case (k)
            3'd0:    coef = {{NUM_OF_INT{1'b0}}, 23'h011111};
            3'd1:    coef = {{NUM_OF_INT{1'b0}}, 23'h055555};
            3'd2:    coef = {{NUM_OF_INT{1'b0}}, 23'h155555};
            3'd3:    coef = {{NUM_OF_INT{1'b0}}, 23'h400000};
            3'd4:    coef = ONE_FIX;
            3'd5:    coef = ONE_FIX;
            default: coef = {W{1'b0}};
        endcase
    endfunction

    logic [2:0]   state_r;
    logic [2:0]   k_r;
    logic [W-1:0] x_r;
    logic [W-1:0] a_r;
    logic [W-1:0] e_r;
    logic [W-1:0] d_r;
    logic [W-1:0] acc_r;
    logic [W-1:0] out_r;
    logic         busy_r;
    logic         done_r;

    logic [W-1:0] add_a_s;
    logic [W-1:0] add_b_s;
    logic [W-1:0] add_sum_s;
    logic [W-1:0] mul_a_s;
    logic [W-1:0] mul_b_s;
    logic [W-1:0] mul_prod_s;

    // Shared-unit operand muxes; idle states feed zeros to keep the units quiet
    always_comb begin
        add_a_s = {W{1'b0}};
        add_b_s = {W{1'b0}};
        mul_a_s = {W{1'b0}};
        mul_b_s = {W{1'b0}};
        case (state_r)
            S_SUB: begin
                add_a_s = x_r;
                add_b_s = ~a_r + ONE_LSB;
            end
            S_ADD: begin
                add_a_s = coef(k_r);
                add_b_s = acc_r;
            end
            S_MUL: begin
                mul_a_s = acc_r;
                mul_b_s = d_r;
            end
            S_FIN: begin
                mul_a_s = acc_r;
                mul_b_s = e_r;
            end
            default: begin
                add_a_s = {W{1'b0}};
                mul_a_s = {W{1'b0}};
            end
        endcase
    end

    assign add_sum_s  = fix_add(add_a_s, add_b_s);
    assign mul_prod_s = fix_mul(mul_a_s, mul_b_s);

    // Sequencer FSM with operand latches, accumulator and registered outputs
    always_ff @(posedge IN_CLK) begin
        if (!IN_RST_N) begin
            state_r <= S_IDLE;
            k_r     <= 3'd0;
            x_r     <= {W{1'b0}};
            a_r     <= {W{1'b0}};
            e_r     <= {W{1'b0}};
            d_r     <= {W{1'b0}};
            acc_r   <= {W{1'b0}};
            out_r   <= {W{1'b0}};
            busy_r  <= 1'b0;
            done_r  <= 1'b0;
        end else begin
            done_r <= 1'b0;
            case (state_r)
                S_IDLE: begin
                    if (IN_START) begin
                        x_r     <= {IN_X_INT, IN_X_FRAC};
                        a_r     <= {IN_A_INT, IN_A_FRAC};
                        e_r     <= {IN_EXP_INT, IN_EXP_FRAC};
                        acc_r   <= INV_720;
                        busy_r  <= 1'b1;
                        state_r <= S_SUB;
                    end else begin
                        state_r <= S_IDLE;
                    end
                end
                S_SUB: begin
                    d_r     <= add_sum_s;
                    k_r     <= 3'd0;
                    state_r <= S_MUL;
                end
                S_MUL: begin
                    acc_r   <= mul_prod_s;
                    state_r <= S_ADD;
                end
                S_ADD: begin
                    acc_r <= add_sum_s;
                    if (k_r == LAST_STEP) begin
                        state_r <= S_FIN;
                    end else begin
                        k_r     <= k_r + 3'd1;
                        state_r <= S_MUL;
                    end
                end
                S_FIN: begin
                    out_r   <= mul_prod_s;
                    done_r  <= 1'b1;
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
                default: begin
                    busy_r  <= 1'b0;
                    state_r <= S_IDLE;
                end
            endcase
        end
    end

    assign OUT_BUSY     = busy_r;
    assign OUT_DONE     = done_r;
    assign OUT_EXP_INT  = out_r[W-1:NUM_OF_FRAC];
    assign OUT_EXP_FRAC = out_r[NUM_OF_FRAC-1:0];

endmodule

// File: tb/tb_taylor_seq.sv
// -----------------------------------------------------------------------------
// tb_taylor_seq
//   Self-checking bench for taylor_seq. Expected results come from a reference
//   model that evaluates the Horner polynomial directly on wide signed
//   integers (value * 2^23), applying wrap and truncation per operation.
// -----------------------------------------------------------------------------
module tb_taylor_seq;

    localparam int NI = 32;
    localparam int NF = 23;
    localparam int W  = NI + NF;

    logic          clk;
    logic          rst_n;
    logic          start;
    logic [NI-1:0] x_int;
    logic [NF-1:0] x_frac;
    logic [NI-1:0] a_int;
    logic [NF-1:0] a_frac;
    logic [NI-1:0] e_int;
    logic [NF-1:0] e_frac;
    logic          busy;
    logic          done;
    logic [NI-1:0] res_int;
    logic [NF-1:0] res_frac;

    int checks = 0;
    int errors = 0;

    taylor_seq #(.NUM_OF_INT(NI), .NUM_OF_FRAC(NF)) dut (
        .IN_CLK       (clk),
        .IN_RST_N     (rst_n),
        .IN_START     (start),
        .IN_X_INT     (x_int),
        .IN_X_FRAC    (x_frac),
        .IN_A_INT     (a_int),
        .IN_A_FRAC    (a_frac),
        .IN_EXP_INT   (e_int),
        .IN_EXP_FRAC  (e_frac),
        .OUT_BUSY     (busy),
        .OUT_DONE     (done),
        .OUT_EXP_INT  (res_int),
        .OUT_EXP_FRAC (res_frac)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Fixed-point product of two W-bit words: exact product, floor-divide by 2^23, wrap to W bits
    function automatic logic [W-1:0] ref_mul(input logic [W-1:0] p, input logic [W-1:0] q);
        logic signed [127:0] sp;
        logic signed [127:0] sq;
        logic signed [127:0] prod;
        sp   = $signed({{(128-W){p[W-1]}}, p});
        sq   = $signed({{(128-W){q[W-1]}}, q});
        prod = (sp * sq) >>> NF;
        return prod[W-1:0];
    endfunction

    // exp(a) * P(x - a) evaluated step by step from the polynomial definition
    function automatic logic [W-1:0] ref_exp(input logic [W-1:0] x, input logic [W-1:0] a,
                                             input logic [W-1:0] e);
        logic [W-1:0] c [6];
        logic [W-1:0] d;
        logic [W-1:0] acc;
        c[0] = {32'd0, 23'h011111};
        c[1] = {32'd0, 23'h055555};
        c[2] = {32'd0, 23'h155555};
        c[3] = {32'd0, 23'h400000};
        c[4] = {32'd1, 23'h000000};
        c[5] = {32'd1, 23'h000000};
        d   = x - a;
        acc = {32'd0, 23'h002D82};
        for (int i = 0; i < 6; i++) begin
            acc = ref_mul(acc, d);
            acc = acc + c[i];
        end
        return ref_mul(acc, e);
    endfunction

    task automatic drive_ops(input logic [W-1:0] x, input logic [W-1:0] a, input logic [W-1:0] e);
        {x_int, x_frac} = x;
        {a_int, a_frac} = a;
        {e_int, e_frac} = e;
    endtask

    task automatic scramble_ops();
        x_int  = $urandom;
        x_frac = NF'($urandom);
        a_int  = $urandom;
        a_frac = NF'($urandom);
        e_int  = $urandom;
        e_frac = NF'($urandom);
    endtask

    function automatic logic [W-1:0] rand_small();
        logic [NI-1:0] ip;
        logic [NF-1:0] fp;
        ip = NI'($urandom_range(0, 7)) - 32'd4;
        fp = NF'($urandom);
        return {ip, fp};
    endfunction

    // One job: accept, busy window, DONE pulse, result check. poke_cycle > 0
    // raises IN_START (with new operands) during that busy cycle.
    task automatic run_job(input logic [W-1:0] x, input logic [W-1:0] a, input logic [W-1:0] e,
                           input int poke_cycle, input string name, output logic [W-1:0] got);
        logic [W-1:0] exp_v;
        exp_v = ref_exp(x, a, e);
        @(negedge clk);
        start = 1'b1;
        drive_ops(x, a, e);
        @(negedge clk);
        for (int i = 1; i <= 14; i++) begin
            start = (i == poke_cycle) ? 1'b1 : 1'b0;
            scramble_ops();
            checks++;
            if (busy !== 1'b1 || done !== 1'b0) begin
                errors++;
                $display("FAIL %s busy_window cycle %0d: busy=%b done=%b required busy=1 done=0",
                         name, i, busy, done);
            end
            @(negedge clk);
        end
        start = 1'b0;
        got = {res_int, res_frac};
        checks++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s done_cycle: done=%b busy=%b required done=1 busy=0", name, done, busy);
        end
        checks++;
        if ({res_int, res_frac} !== exp_v) begin
            errors++;
            $display("FAIL %s result: got %h required %h", name, {res_int, res_frac}, exp_v);
        end
        @(negedge clk);
        checks++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            errors++;
            $display("FAIL %s after_done: done=%b busy=%b required 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        start = 1'b1;
        rst_n = 1'b0;
        drive_ops({32'd3, 23'd5}, {32'd1, 23'd0}, {32'd1, 23'd0});
        for (int i = 0; i < 2; i++) begin
            @(negedge clk);
            checks++;
            if (busy !== 1'b0 || done !== 1'b0 || res_int !== 32'd0 || res_frac !== 23'd0) begin
                errors++;
                $display("FAIL reset cycle %0d: busy=%b done=%b out=%h required 0 0 0",
                         i, busy, done, {res_int, res_frac});
            end
        end
        start = 1'b0;
        rst_n = 1'b1;
        @(negedge clk);
        checks++;
        if (busy !== 1'b0) begin
            errors++;
            $display("FAIL reset_no_accept: busy=%b required 0", busy);
        end
    endtask

    task automatic test_zero_delta();
        logic [W-1:0] got;
        run_job({32'd2, 23'd0}, {32'd2, 23'd0}, {32'd1, 23'd0}, 0, "zero_delta", got);
        checks++;
        if (got !== {32'd1, 23'd0}) begin
            errors++;
            $display("FAIL zero_delta_const: got %h required %h", got, {32'd1, 23'd0});
        end
    endtask

    task automatic test_e_value();
        logic [W-1:0] got;
        real          v;
        run_job({32'd1, 23'd0}, {32'd0, 23'd0}, {32'd1, 23'd0}, 0, "exp_one", got);
        v = real'(got[NF-1:0]) / 8388608.0 + real'(got[W-1:NF]);
        checks++;
        if (got[W-1:NF] !== 32'd2 || v < 2.7170 || v > 2.7190) begin
            errors++;
            $display("FAIL exp_one_value: got %f required about 2.71806", v);
        end
    endtask

    task automatic test_random();
        logic [W-1:0] got;
        for (int n = 0; n < 6; n++) begin
            run_job(rand_small(), rand_small(), {NI'($urandom_range(0, 3)), NF'($urandom)}, 0,
                    "random", got);
        end
    endtask

    task automatic test_ignored_start();
        logic [W-1:0] got;
        run_job({32'd0, 23'h200000}, {32'hFFFF_FFFF, 23'h600000}, {32'd2, 23'h1234}, 5,
                "ignored_start", got);
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] s1x, s1a, s1e, s2x, s2a, s2e;
        int           done_at [$];
        logic [W-1:0] res_q [$];
        s1x = rand_small(); s1a = rand_small(); s1e = {32'd1, NF'($urandom)};
        s2x = rand_small(); s2a = rand_small(); s2e = {32'd2, NF'($urandom)};
        @(negedge clk);
        start = 1'b1;
        drive_ops(s1x, s1a, s1e);
        // cycle c is the interval after edge c-1 (edge 0 = first accept)
        for (int c = 1; c <= 34; c++) begin
            @(negedge clk);
            if (c == 1) drive_ops(s2x, s2a, s2e);
            if (c == 16) start = 1'b0;
            if (done === 1'b1) begin
                done_at.push_back(c);
                res_q.push_back({res_int, res_frac});
            end
        end
        start = 1'b0;
        checks++;
        if (done_at.size() != 2) begin
            errors++;
            $display("FAIL b2b_done_count: got %0d required 2", done_at.size());
        end else begin
            checks++;
            if (done_at[0] != 15 || done_at[1] != 30) begin
                errors++;
                $display("FAIL b2b_timing: done at %0d,%0d required 15,30", done_at[0], done_at[1]);
            end
            checks++;
            if (res_q[0] !== ref_exp(s1x, s1a, s1e) || res_q[1] !== ref_exp(s2x, s2a, s2e)) begin
                errors++;
                $display("FAIL b2b_results: got %h,%h required %h,%h", res_q[0], res_q[1],
                         ref_exp(s1x, s1a, s1e), ref_exp(s2x, s2a, s2e));
            end
        end
    endtask

    task automatic test_abort();
        logic [W-1:0] got;
        int           seen;
        @(negedge clk);
        start = 1'b1;
        drive_ops({32'd3, 23'd0}, {32'd1, 23'd0}, {32'd1, 23'd0});
        @(negedge clk);
        start = 1'b0;
        for (int i = 1; i < 7; i++) @(negedge clk);
        rst_n = 1'b0;
        @(negedge clk);
        rst_n = 1'b1;
        checks++;
        if (busy !== 1'b0 || done !== 1'b0 || {res_int, res_frac} !== {W{1'b0}}) begin
            errors++;
            $display("FAIL abort_reset: busy=%b done=%b out=%h required 0 0 0",
                     busy, done, {res_int, res_frac});
        end
        seen = 0;
        for (int i = 0; i < 20; i++) begin
            @(negedge clk);
            if (done === 1'b1 || busy === 1'b1) seen++;
        end
        checks++;
        if (seen != 0) begin
            errors++;
            $display("FAIL abort_quiet: %0d active cycles required 0", seen);
        end
        run_job({32'd0, 23'h155555}, {32'd0, 23'h0AAAAA}, {32'd1, 23'h3AB000}, 0, "after_abort", got);
    endtask

    initial begin
        rst_n = 1'b0;
        start = 1'b0;
        drive_ops({W{1'b0}}, {W{1'b0}}, {W{1'b0}});
        test_reset();
        test_zero_delta();
        test_e_value();
        test_random();
        test_ignored_start();
        test_back_to_back();
        test_abort();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
